// File: rtl/pipe_robot_pkg.sv
// ---------------------------------------------------------------------------
// pipe_robot_pkg
// Shared definitions for the pipe-cleaning robot environment model.
//   - DEF_ROWS / DEF_COLS / DEF_MOVES_W : default map size and move counter width
//   - dir_t      : robot orientation codes (DIR_N/S/E/W)
//   - cell_t     : 3-bit map cell code, with the named codes CELL_*
//   - remState_t : progress through the three-step barrier removal sequence
//   - turnLeft() : orientation after a left rotation
// ---------------------------------------------------------------------------
package pipe_robot_pkg;

   localparam int DEF_ROWS    = 10;
   localparam int DEF_COLS    = 20;
   localparam int DEF_MOVES_W = 9;

   typedef enum logic [1:0] {
      DIR_N = 2'b00,
      DIR_S = 2'b01,
      DIR_E = 2'b10,
      DIR_W = 2'b11
   } dir_t;

   // Cells keep their raw 3-bit code; codes without a name here behave as empty.
   typedef logic [2:0] cell_t;

   localparam cell_t CELL_EMPTY   = 3'd0;
   localparam cell_t CELL_WALL    = 3'd1;
   localparam cell_t CELL_BARRIER = 3'd2;
   localparam cell_t CELL_TRASH   = 3'd7;

   // How many consecutive remove steps have already been seen.
   typedef enum logic [1:0] {
      REM_IDLE = 2'd0,
      REM_ONE  = 2'd1,
      REM_TWO  = 2'd2
   } remState_t;

   // Left rotation: N->W, W->S, S->E, E->N.
   function automatic dir_t turnLeft(input dir_t d);
      dir_t result;
      case (d)
         DIR_N:   result = DIR_W;
         DIR_W:   result = DIR_S;
         DIR_S:   result = DIR_E;
         default: result = DIR_N;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/pipe_neighbour_lookup.sv
// ---------------------------------------------------------------------------
// pipe_neighbour_lookup
// Purely combinational view of the map around the robot.
//   i_map        : full pipe map, indexed [row-1][col-1]
//   i_row/i_col  : current pose, 1-based
//   i_dir        : current orientation
//   o_hereCode   : code of the cell under the robot (empty if pose is off-map)
//   o_aheadCode  : code of the cell ahead (empty if off-map)
//   o_leftCode   : code of the cell on the robot's left (empty if off-map)
//   o_aheadOff   : cell ahead lies outside the map
//   o_leftOff    : cell on the left lies outside the map
//   o_aheadRow/o_aheadCol : coordinates of the cell ahead (valid when on-map)
// ---------------------------------------------------------------------------
module pipe_neighbour_lookup
   import pipe_robot_pkg::*;
#(
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS
) (
   input  cell_t       i_map [ROWS][COLS],
   input  logic [3:0]  i_row,
   input  logic [4:0]  i_col,
   input  dir_t        i_dir,
   output cell_t       o_hereCode,
   output cell_t       o_aheadCode,
   output cell_t       o_leftCode,
   output logic        o_aheadOff,
   output logic        o_leftOff,
   output logic [3:0]  o_aheadRow,
   output logic [4:0]  o_aheadCol
);

   localparam int RIW = $clog2(ROWS);
   localparam int CIW = $clog2(COLS);

   logic [5:0] w_rowX;
   logic [5:0] w_colX;
   logic [5:0] w_aheadRow;
   logic [5:0] w_aheadCol;
   logic [5:0] w_leftRow;
   logic [5:0] w_leftCol;

   // Coordinates are widened to 6 bits so that stepping off row/col 1 wraps to a
   // large value and is caught by the same upper-bound check as the far edges.
   function automatic logic onMap(input logic [5:0] r, input logic [5:0] c);
      return (r >= 6'd1) && (r <= 6'(ROWS)) && (c >= 6'd1) && (c <= 6'(COLS));
   endfunction

   assign w_rowX = {2'b00, i_row};
   assign w_colX = {1'b0, i_col};

   // The left neighbour sits one quarter-turn anticlockwise from the heading:
   // north looks west, south looks east, east looks north, west looks south.
   always_comb begin
      w_aheadRow = w_rowX;
      w_aheadCol = w_colX;
      w_leftRow  = w_rowX;
      w_leftCol  = w_colX;
      case (i_dir)
         DIR_N: begin
            w_aheadRow = w_rowX - 6'd1;
            w_leftCol  = w_colX - 6'd1;
         end
         DIR_S: begin
            w_aheadRow = w_rowX + 6'd1;
            w_leftCol  = w_colX + 6'd1;
         end
         DIR_E: begin
            w_aheadCol = w_colX + 6'd1;
            w_leftRow  = w_rowX - 6'd1;
         end
         DIR_W: begin
            w_aheadCol = w_colX - 6'd1;
            w_leftRow  = w_rowX + 6'd1;
         end
      endcase
   end

   // Off-map cells read as empty here; the caller turns the edge flags into walls.
   assign o_aheadOff  = !onMap(w_aheadRow, w_aheadCol);
   assign o_leftOff   = !onMap(w_leftRow, w_leftCol);
   assign o_hereCode  = onMap(w_rowX, w_colX)
                        ? i_map[RIW'(w_rowX - 6'd1)][CIW'(w_colX - 6'd1)] : CELL_EMPTY;
   assign o_aheadCode = !o_aheadOff
                        ? i_map[RIW'(w_aheadRow - 6'd1)][CIW'(w_aheadCol - 6'd1)] : CELL_EMPTY;
   assign o_leftCode  = !o_leftOff
                        ? i_map[RIW'(w_leftRow - 6'd1)][CIW'(w_leftCol - 6'd1)] : CELL_EMPTY;
   assign o_aheadRow  = 4'(w_aheadRow);
   assign o_aheadCol  = 5'(w_aheadCol);

endmodule

// File: rtl/pipe_env_sensor_model.sv
// ---------------------------------------------------------------------------
// pipe_env_sensor_model
// Closed-loop environment for the pipe-cleaning robot controller: holds the
// pipe map and robot pose, applies front/turn/remove commands and returns the
// registered head/left/under/barrier sensors.
//
// Ports
//   clock, reset            : posedge clock, synchronous active-low reset
//                             (map contents survive reset)
//   load_en/row/col/cell    : write one map cell (lowest priority)
//   start, start_row/col/dir, max_moves : load pose and move limit
//   step_en, front, turn, remove        : controller command for this cycle
//   head, left, under, barrier          : registered sensors for the controller
//   row, col, dir, move_count, done     : pose and step accounting
//   collision, out_of_map               : sticky checker flags
//
// Build option
//   PIPE_ENV_TRASH_CLEAN_EN : when defined, a trash cell (code 7) is cleared
//   as the robot leaves it with a successful front step.
// ---------------------------------------------------------------------------
module pipe_env_sensor_model
   import pipe_robot_pkg::*;
#(
   parameter int ROWS    = DEF_ROWS,
   parameter int COLS    = DEF_COLS,
   parameter int MOVES_W = DEF_MOVES_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load_en,
   input  logic [3:0]         load_row,
   input  logic [4:0]         load_col,
   input  logic [2:0]         load_cell,
   input  logic               start,
   input  logic [3:0]         start_row,
   input  logic [4:0]         start_col,
   input  logic [1:0]         start_dir,
   input  logic [MOVES_W-1:0] max_moves,
   input  logic               step_en,
   input  logic               front,
   input  logic               turn,
   input  logic               remove,
   output logic               head,
   output logic               left,
   output logic               under,
   output logic               barrier,
   output logic [3:0]         row,
   output logic [4:0]         col,
   output logic [1:0]         dir,
   output logic [MOVES_W-1:0] move_count,
   output logic               done,
   output logic               collision,
   output logic               out_of_map
);

   localparam int RIW = $clog2(ROWS);
   localparam int CIW = $clog2(COLS);

   cell_t              r_map [ROWS][COLS];
   logic [3:0]         r_row;
   logic [4:0]         r_col;
   dir_t               r_dir;
   logic [MOVES_W-1:0] r_moveCount;
   logic [MOVES_W-1:0] r_maxMoves;
   logic               r_done;
   logic               r_collision;
   logic               r_outOfMap;
   remState_t          r_remState;
   logic               r_head;
   logic               r_left;
   logic               r_under;
   logic               r_barrier;

   logic [3:0]         w_nextRow;
   logic [4:0]         w_nextCol;
   dir_t               w_nextDir;
   logic [MOVES_W-1:0] w_nextMoveCount;
   logic [MOVES_W-1:0] w_nextMaxMoves;
   logic               w_nextDone;
   logic               w_nextCollision;
   logic               w_nextOutOfMap;
   remState_t          w_nextRemState;
   logic [MOVES_W-1:0] w_countInc;

   cell_t              w_hereCode;
   cell_t              w_aheadCode;
   cell_t              w_leftCode;
   logic               w_aheadOff;
   logic               w_leftOff;
   logic [3:0]         w_aheadRow;
   logic [4:0]         w_aheadCol;
   logic               w_headNow;
   logic               w_leftNow;
   logic               w_underNow;
   logic               w_barrierNow;
   logic               w_poseBad;
   logic               w_loadInRange;

   logic               w_mapWe;
   logic [3:0]         w_mapRow;
   logic [4:0]         w_mapCol;
   cell_t              w_mapData;

   pipe_neighbour_lookup #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_lookup (
      .i_map       (r_map),
      .i_row       (r_row),
      .i_col       (r_col),
      .i_dir       (r_dir),
      .o_hereCode  (w_hereCode),
      .o_aheadCode (w_aheadCode),
      .o_leftCode  (w_leftCode),
      .o_aheadOff  (w_aheadOff),
      .o_leftOff   (w_leftOff),
      .o_aheadRow  (w_aheadRow),
      .o_aheadCol  (w_aheadCol)
   );

   // Sensor values for the pose held right now. Step decisions use these directly
   // rather than the registered copies, so the robot can never walk into a wall
   // even if the controller issues steps back to back.
   assign w_headNow    = w_aheadOff || (w_aheadCode == CELL_WALL) || (w_aheadCode == CELL_BARRIER);
   assign w_leftNow    = w_leftOff || (w_leftCode == CELL_WALL);
   assign w_underNow   = (w_hereCode == CELL_TRASH);
   assign w_barrierNow = !w_aheadOff && (w_aheadCode == CELL_BARRIER);

   assign w_poseBad     = (r_row == 4'd0) || (r_row > 4'(ROWS)) ||
                          (r_col == 5'd0) || (r_col > 5'(COLS));
   assign w_loadInRange = (load_row >= 4'd1) && (load_row <= 4'(ROWS)) &&
                          (load_col >= 5'd1) && (load_col <= 5'(COLS));
   assign w_countInc    = r_moveCount + 1'b1;

   // Next-state and map-write decode. Start beats a step, a step beats a load,
   // and a step arriving once done is set changes nothing at all. Every accepted
   // step that is not a plain remove breaks the removal streak.
   always_comb begin
      w_nextRow       = r_row;
      w_nextCol       = r_col;
      w_nextDir       = r_dir;
      w_nextMoveCount = r_moveCount;
      w_nextMaxMoves  = r_maxMoves;
      w_nextDone      = r_done;
      w_nextCollision = r_collision;
      w_nextOutOfMap  = r_outOfMap | w_poseBad;
      w_nextRemState  = r_remState;
      w_mapWe         = 1'b0;
      w_mapRow        = 4'd0;
      w_mapCol        = 5'd0;
      w_mapData       = CELL_EMPTY;

      if (start) begin
         w_nextRow       = start_row;
         w_nextCol       = start_col;
         w_nextDir       = dir_t'(start_dir);
         w_nextMoveCount = '0;
         w_nextMaxMoves  = max_moves;
         w_nextDone      = (max_moves == '0);
         w_nextCollision = 1'b0;
         w_nextOutOfMap  = 1'b0;
         w_nextRemState  = REM_IDLE;
      end else if (step_en) begin
         if (!r_done) begin
            w_nextMoveCount = w_countInc;
            w_nextDone      = (w_countInc == r_maxMoves);
            w_nextRemState  = REM_IDLE;
            if (front) begin
               if (w_headNow) begin
                  w_nextCollision = 1'b1;
               end else begin
                  case (r_dir)
                     DIR_N: w_nextRow = r_row - 4'd1;
                     DIR_S: w_nextRow = r_row + 4'd1;
                     DIR_E: w_nextCol = r_col + 5'd1;
                     DIR_W: w_nextCol = r_col - 5'd1;
                  endcase
`ifdef PIPE_ENV_TRASH_CLEAN_EN
                  if (w_hereCode == CELL_TRASH) begin
                     w_mapWe   = 1'b1;
                     w_mapRow  = r_row;
                     w_mapCol  = r_col;
                     w_mapData = CELL_EMPTY;
                  end
`else
                  w_mapWe = 1'b0;
`endif
               end
            end else if (turn) begin
               w_nextDir = turnLeft(r_dir);
            end else if (remove) begin
               case (r_remState)
                  REM_IDLE: w_nextRemState = REM_ONE;
                  REM_ONE:  w_nextRemState = REM_TWO;
                  default: begin
                     w_nextRemState = REM_IDLE;
                     if (w_barrierNow) begin
                        w_mapWe   = 1'b1;
                        w_mapRow  = w_aheadRow;
                        w_mapCol  = w_aheadCol;
                        w_mapData = CELL_EMPTY;
                     end
                  end
               endcase
            end
         end
      end else if (load_en && w_loadInRange) begin
         w_mapWe   = 1'b1;
         w_mapRow  = load_row;
         w_mapCol  = load_col;
         w_mapData = load_cell;
      end

      // A reset cycle must never disturb the map, even mid-removal.
      if (!reset) begin
         w_mapWe = 1'b0;
      end
   end

   // Pose, accounting and sensor registers. Sensors always follow the pose one
   // cycle later, which is when the controller is expected to sample them.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_row       <= 4'd1;
         r_col       <= 5'd1;
         r_dir       <= DIR_N;
         r_moveCount <= '0;
         r_maxMoves  <= '1;
         r_done      <= 1'b0;
         r_collision <= 1'b0;
         r_outOfMap  <= 1'b0;
         r_remState  <= REM_IDLE;
         r_head      <= 1'b0;
         r_left      <= 1'b0;
         r_under     <= 1'b0;
         r_barrier   <= 1'b0;
      end else begin
         r_row       <= w_nextRow;
         r_col       <= w_nextCol;
         r_dir       <= w_nextDir;
         r_moveCount <= w_nextMoveCount;
         r_maxMoves  <= w_nextMaxMoves;
         r_done      <= w_nextDone;
         r_collision <= w_nextCollision;
         r_outOfMap  <= w_nextOutOfMap;
         r_remState  <= w_nextRemState;
         r_head      <= w_headNow;
         r_left      <= w_leftNow;
         r_under     <= w_underNow;
         r_barrier   <= w_barrierNow;
      end
   end

   // Map storage has no reset so a loaded map survives controller restarts.
   always_ff @(posedge clock) begin
      if (w_mapWe) begin
         r_map[RIW'(w_mapRow - 4'd1)][CIW'(w_mapCol - 5'd1)] <= w_mapData;
      end
   end

   assign head       = r_head;
   assign left       = r_left;
   assign under      = r_under;
   assign barrier    = r_barrier;
   assign row        = r_row;
   assign col        = r_col;
   assign dir        = r_dir;
   assign move_count = r_moveCount;
   assign done       = r_done;
   assign collision  = r_collision;
   assign out_of_map = r_outOfMap;

endmodule

// File: tb/tb_pipe_env_sensor_model.sv
// ---------------------------------------------------------------------------
// tb_pipe_env_sensor_model
// Drives directed and random commands into pipe_env_sensor_model. Each command
// updates a cell-array model of the pipe world and queues the response the
// outputs must show two cycles later; an independent monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_pipe_env_sensor_model;

   localparam int ROWS = 10;
   localparam int COLS = 20;
   localparam int MW   = 9;

   logic          clock = 1'b0;
   logic          reset;
   logic          load_en;
   logic [3:0]    load_row;
   logic [4:0]    load_col;
   logic [2:0]    load_cell;
   logic          start;
   logic [3:0]    start_row;
   logic [4:0]    start_col;
   logic [1:0]    start_dir;
   logic [MW-1:0] max_moves;
   logic          step_en;
   logic          front;
   logic          turn;
   logic          remove;
   logic          head;
   logic          left;
   logic          under;
   logic          barrier;
   logic [3:0]    row;
   logic [4:0]    col;
   logic [1:0]    dir;
   logic [MW-1:0] move_count;
   logic          done;
   logic          collision;
   logic          out_of_map;

   pipe_env_sensor_model dut (
      .clock      (clock),
      .reset      (reset),
      .load_en    (load_en),
      .load_row   (load_row),
      .load_col   (load_col),
      .load_cell  (load_cell),
      .start      (start),
      .start_row  (start_row),
      .start_col  (start_col),
      .start_dir  (start_dir),
      .max_moves  (max_moves),
      .step_en    (step_en),
      .front      (front),
      .turn       (turn),
      .remove     (remove),
      .head       (head),
      .left       (left),
      .under      (under),
      .barrier    (barrier),
      .row        (row),
      .col        (col),
      .dir        (dir),
      .move_count (move_count),
      .done       (done),
      .collision  (collision),
      .out_of_map (out_of_map)
   );

   always #5 clock = ~clock;

   // Free-running posedge count; responses are scheduled against it.
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int due;
      int txn;
      int row, col, dir, cnt, done, coll, oom;
      int head, left, under, barrier;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;
   int   txnId = 0;

   // World model: direction 0=N 1=S 2=E 3=W; off-map cells read as -1.
   int mMap [1:ROWS][1:COLS];
   int mRow, mCol, mDir, mCnt, mMax, mDone, mColl, mOom, mRem;
   int dRow     [4] = '{-1, 1, 0, 0};
   int dCol     [4] = '{0, 0, 1, -1};
   int leftTurn [4] = '{3, 2, 0, 1};

   function automatic bit onMap(int r, int c);
      return (r >= 1) && (r <= ROWS) && (c >= 1) && (c <= COLS);
   endfunction

   function automatic int cellAt(int r, int c);
      if (!onMap(r, c)) return -1;
      return mMap[r][c];
   endfunction

   function automatic int aheadCell();
      return cellAt(mRow + dRow[mDir], mCol + dCol[mDir]);
   endfunction

   function automatic int headSense();
      int c = aheadCell();
      return (c == -1 || c == 1 || c == 2) ? 1 : 0;
   endfunction

   function automatic int leftSense();
      int ld = leftTurn[mDir];
      int c  = cellAt(mRow + dRow[ld], mCol + dCol[ld]);
      return (c == -1 || c == 1) ? 1 : 0;
   endfunction

   // Apply whatever is currently on the DUT inputs to the world model.
   task automatic modelApply();
      int ar, ac;
      if (!reset) begin
         mRow = 1; mCol = 1; mDir = 0; mCnt = 0; mMax = -1;
         mDone = 0; mColl = 0; mOom = 0; mRem = 0;
      end else if (start) begin
         mRow = int'(start_row); mCol = int'(start_col); mDir = int'(start_dir);
         mCnt = 0; mMax = int'(max_moves); mDone = (mMax == 0) ? 1 : 0;
         mColl = 0; mOom = 0; mRem = 0;
      end else if (step_en) begin
         if (mDone == 0) begin
            ar = mRow + dRow[mDir];
            ac = mCol + dCol[mDir];
            mCnt = (mCnt + 1) % (1 << MW);
            mDone = (mCnt == mMax) ? 1 : 0;
            if (front) begin
               if (headSense() == 1) begin
                  mColl = 1;
               end else begin
`ifdef PIPE_ENV_TRASH_CLEAN_EN
                  if (mMap[mRow][mCol] == 7) mMap[mRow][mCol] = 0;
`endif
                  mRow = ar;
                  mCol = ac;
               end
               mRem = 0;
            end else if (turn) begin
               mDir = leftTurn[mDir];
               mRem = 0;
            end else if (remove) begin
               if (mRem == 2) begin
                  if (cellAt(ar, ac) == 2) mMap[ar][ac] = 0;
                  mRem = 0;
               end else begin
                  mRem = mRem + 1;
               end
            end else begin
               mRem = 0;
            end
         end
      end else if (load_en) begin
         if (onMap(int'(load_row), int'(load_col)))
            mMap[int'(load_row)][int'(load_col)] = int'(load_cell);
      end
   endtask

   // Called at a negedge with inputs driven: update the model, queue the response
   // expected two posedges later, then hold for one cycle and idle for one.
   task automatic applyStimulus(input bit chk);
      exp_t e;
      modelApply();
      if (chk) begin
         txnId++;
         e.due = cyc + 2;  e.txn = txnId;
         e.row = mRow;     e.col = mCol;    e.dir = mDir;
         e.cnt = mCnt;     e.done = mDone;  e.coll = mColl;  e.oom = mOom;
         e.head = headSense();
         e.left = leftSense();
         e.under = (cellAt(mRow, mCol) == 7) ? 1 : 0;
         e.barrier = (aheadCell() == 2) ? 1 : 0;
         expQ.push_back(e);
      end
      @(negedge clock);
      reset = 1'b1; load_en = 1'b0; start = 1'b0; step_en = 1'b0;
      front = 1'b0; turn = 1'b0; remove = 1'b0;
      @(negedge clock);
   endtask

   task automatic checkOutput(input exp_t e);
      total++;
      if (int'(row) != e.row || int'(col) != e.col || int'(dir) != e.dir) begin
         bad++;
         $display("[TB] FAIL pose txn=%0d got r=%0d c=%0d d=%0d want r=%0d c=%0d d=%0d",
                  e.txn, row, col, dir, e.row, e.col, e.dir);
      end
      total++;
      if (int'(move_count) != e.cnt || int'(done) != e.done ||
          int'(collision) != e.coll || int'(out_of_map) != e.oom) begin
         bad++;
         $display("[TB] FAIL status txn=%0d got cnt=%0d done=%0d coll=%0d oom=%0d want cnt=%0d done=%0d coll=%0d oom=%0d",
                  e.txn, move_count, done, collision, out_of_map, e.cnt, e.done, e.coll, e.oom);
      end
      total++;
      if (int'(head) != e.head || int'(left) != e.left ||
          int'(under) != e.under || int'(barrier) != e.barrier) begin
         bad++;
         $display("[TB] FAIL sensors txn=%0d got h=%0d l=%0d u=%0d b=%0d want h=%0d l=%0d u=%0d b=%0d",
                  e.txn, head, left, under, barrier, e.head, e.left, e.under, e.barrier);
      end
   endtask

   // Monitor: compares each queued response on the negedge it falls due.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         while (expQ.size() > 0 && expQ[0].due <= cyc) begin
            e = expQ.pop_front();
            if (e.due < cyc) begin
               total++;
               bad++;
               $display("[TB] FAIL late txn=%0d got cycle=%0d want cycle=%0d", e.txn, cyc, e.due);
            end else begin
               checkOutput(e);
            end
         end
      end
   end

   task automatic doLoad(input int r, input int c, input int code, input bit chk);
      load_en = 1'b1; load_row = 4'(r); load_col = 5'(c); load_cell = 3'(code);
      applyStimulus(chk);
   endtask

   task automatic doStart(input int r, input int c, input int d, input int mm);
      start = 1'b1; start_row = 4'(r); start_col = 5'(c);
      start_dir = 2'(d); max_moves = MW'(mm);
      applyStimulus(1'b1);
   endtask

   task automatic doStep(input bit f, input bit t, input bit rm);
      step_en = 1'b1; front = f; turn = t; remove = rm;
      applyStimulus(1'b1);
   endtask

   task automatic doReset();
      reset = 1'b0;
      applyStimulus(1'b1);
   endtask

   initial begin
      int op, kind, codes[5];
      codes = '{0, 1, 2, 7, 3};
      reset = 1'b0; load_en = 1'b0; load_row = '0; load_col = '0; load_cell = '0;
      start = 1'b0; start_row = '0; start_col = '0; start_dir = '0; max_moves = '0;
      step_en = 1'b0; front = 1'b0; turn = 1'b0; remove = 1'b0;
      @(negedge clock);
      applyStimulus(1'b0);

      // Empty map, then reset state check.
      for (int r = 1; r <= ROWS; r++)
         for (int c = 1; c <= COLS; c++)
            doLoad(r, c, 0, 1'b0);
      doReset();

      $display("[TB] straight run to move limit");
      doStart(5, 10, 2, 3);
      repeat (4) doStep(1'b1, 1'b0, 1'b0);

      $display("[TB] corner collision");
      doStart(1, 1, 0, 20);
      doStep(1'b1, 1'b0, 1'b0);
      doStep(1'b1, 1'b1, 1'b0);

      $display("[TB] full left rotation");
      doStart(3, 3, 0, 20);
      repeat (4) doStep(1'b0, 1'b1, 1'b0);

      $display("[TB] barrier removal");
      doLoad(4, 5, 2, 1'b1);
      doStart(5, 5, 0, 50);
      repeat (3) doStep(1'b0, 1'b0, 1'b1);
      doLoad(4, 5, 2, 1'b1);
      doStep(1'b0, 1'b0, 1'b1);
      doStep(1'b0, 1'b0, 1'b1);
      doStep(1'b1, 1'b0, 1'b0);
      doStep(1'b0, 1'b0, 1'b1);

      $display("[TB] trash cell");
      doLoad(2, 2, 7, 1'b1);
      doStart(2, 2, 2, 50);
      doStep(1'b1, 1'b0, 1'b0);
      doStep(1'b0, 1'b1, 1'b0);
      doStep(1'b0, 1'b1, 1'b0);
      doStep(1'b1, 1'b0, 1'b0);

      $display("[TB] reset during removal");
      doStart(5, 5, 0, 50);
      doStep(1'b0, 1'b0, 1'b1);
      step_en = 1'b1; remove = 1'b1; reset = 1'b0;
      applyStimulus(1'b1);
      doStart(5, 5, 0, 50);
      repeat (3) doStep(1'b0, 1'b0, 1'b1);

      $display("[TB] dropped and blocked loads");
      doStart(1, 1, 2, 50);
      doLoad(0, 2, 1, 1'b1);
      doLoad(11, 2, 1, 1'b1);
      doLoad(1, 21, 1, 1'b1);
      doLoad(2, 0, 1, 1'b1);
      load_en = 1'b1; load_row = 4'd1; load_col = 5'd2; load_cell = 3'd1;
      doStep(1'b0, 1'b0, 1'b0);
      doStart(1, 1, 0, 0);
      doStep(1'b0, 1'b1, 1'b0);

      $display("[TB] random commands");
      for (int i = 0; i < 600; i++) begin
         op = int'($urandom_range(0, 99));
         if (op < 7 || (mDone == 1 && op < 40)) begin
            if ($urandom_range(0, 3) == 0) begin
               step_en = 1'b1; front = 1'b1;
            end
            doStart(int'($urandom_range(1, ROWS)), int'($urandom_range(1, COLS)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 40)));
         end else if (op < 22) begin
            doLoad(int'($urandom_range(0, 11)), int'($urandom_range(0, 21)),
                   codes[$urandom_range(0, 4)], 1'b1);
         end else if (op < 24) begin
            doReset();
            doStart(int'($urandom_range(1, ROWS)), int'($urandom_range(1, COLS)),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 40)));
         end else begin
            if (op < 28) begin
               load_en = 1'b1; load_row = 4'($urandom_range(1, ROWS));
               load_col = 5'($urandom_range(1, COLS)); load_cell = 3'(codes[$urandom_range(0, 4)]);
            end
            kind = int'($urandom_range(0, 9));
            if (kind < 3)      doStep(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else if (kind < 5) doStep(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            else if (kind < 9) doStep(1'b0, 1'b0, 1'b1);
            else               doStep(1'b0, 1'b0, 1'b0);
         end
      end

      // Bounded drain of outstanding responses.
      for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clock);
      @(negedge clock);
      if (expQ.size() > 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain got pending=%0d want pending=0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
